// File: rtl/imem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_arb_pkg
//  Description : Shared definitions for the instruction-memory arbiter.
//                Holds the default code-region base address and the
//                encoding of the response-owner register.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_arb_pkg;

    // Default byte base address of the code region.
    localparam logic [31:0] IMEM_CODE_BASE = 32'h0000_3000;

    // Which requester owns the response returned in the next cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

endpackage : imem_arb_pkg
`default_nettype wire

// File: rtl/imem_range_chk.sv
`default_nettype none
// ============================================================================
//  Module      : imem_range_chk
//  Description : Combinational code-region address check. Converts a byte
//                address into a word index relative to CODE_BASE and flags
//                whether the address is word-aligned and inside the region.
//  Ports       : i_addr  - byte address to check
//                o_ok    - aligned and CODE_BASE <= addr < CODE_BASE+4*2^ADDR_W
//                o_idx   - word index (addr - CODE_BASE) >> 2
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_range_chk
    import imem_arb_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] CODE_BASE = IMEM_CODE_BASE
) (
    input  logic [31:0]       i_addr,
    output logic              o_ok,
    output logic [ADDR_W-1:0] o_idx
);

    // 33-bit difference: bit 32 set means the address lies below the base,
    // and no wrap is possible near the top of the 32-bit space.
    logic [32:0] w_diff;
    logic        w_below;
    logic        w_above;
    logic        w_aligned;

    assign w_diff    = {1'b0, i_addr} - {1'b0, CODE_BASE};
    assign w_below   = w_diff[32];
    // Any offset bit above the region size means the address is past the end.
    assign w_above   = ((w_diff[31:0] >> (ADDR_W + 2)) != 32'd0);
    assign w_aligned = (i_addr[1:0] == 2'b00);

    assign o_ok  = w_aligned && !w_below && !w_above;
    assign o_idx = w_diff[ADDR_W+1:2];

endmodule : imem_range_chk
`default_nettype wire

// File: rtl/imem_arb.sv
`default_nettype none
// ============================================================================
//  Module      : imem_arb
//  Description : Arbiter/sequencer for the single-ported code memory shared
//                by instruction fetch and a data-side requester (loads and
//                stores into the code region, or the boot loader). One access
//                is granted per cycle; its response is returned exactly one
//                cycle later. Data has priority, but fetch is forced through
//                after STARVE_MAX consecutive denied cycles. A fetch redirect
//                (i_if_flush) kills the fetch response presented that cycle.
//  Ports       : clk, rst                 - clock, async active-high reset
//                i_if_*/o_if_*            - fetch request / grant / response
//                i_d_*/o_d_*              - data request / grant / response
//                o_mem_*/i_mem_rdata      - code memory port (1-cycle read)
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_arb
    import imem_arb_pkg::*;
#(
    parameter int          ADDR_W     = 12,
    parameter logic [31:0] CODE_BASE  = IMEM_CODE_BASE,
    parameter int          STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,

    // Fetch side
    input  logic              i_if_req,
    input  logic [31:0]       i_if_addr,
    input  logic              i_if_flush,
    output logic              o_if_gnt,
    output logic              o_if_rvalid,
    output logic [31:0]       o_if_rdata,
    output logic              o_if_err,

    // Data side
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [31:0]       i_d_addr,
    input  logic [31:0]       i_d_wdata,
    output logic              o_d_gnt,
    output logic              o_d_rvalid,
    output logic [31:0]       o_d_rdata,
    output logic              o_d_err,

    // Code memory
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata
);

    localparam int                c_SW         = $clog2(STARVE_MAX + 1);
    localparam logic [c_SW-1:0]   c_STARVE_MAX = c_SW'(STARVE_MAX);
    localparam logic [c_SW-1:0]   c_STARVE_ONE = c_SW'(1);

    // ------------------------------------------------------------------
    // Address checks
    // ------------------------------------------------------------------
    logic              w_if_ok;
    logic [ADDR_W-1:0] w_if_idx;
    logic              w_d_ok;
    logic [ADDR_W-1:0] w_d_idx;

    imem_range_chk #(
        .ADDR_W    (ADDR_W),
        .CODE_BASE (CODE_BASE)
    ) u_if_chk (
        .i_addr (i_if_addr),
        .o_ok   (w_if_ok),
        .o_idx  (w_if_idx)
    );

    imem_range_chk #(
        .ADDR_W    (ADDR_W),
        .CODE_BASE (CODE_BASE)
    ) u_d_chk (
        .i_addr (i_d_addr),
        .o_ok   (w_d_ok),
        .o_idx  (w_d_idx)
    );

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [c_SW-1:0] r_starve;
    logic            w_starved;
    logic            w_if_win;
    logic            w_d_win;

    assign w_starved = (r_starve == c_STARVE_MAX);
    assign w_if_win  = i_if_req && (!i_d_req || w_starved);
    assign w_d_win   = i_d_req && !w_if_win;

    assign o_if_gnt  = w_if_win;
    assign o_d_gnt   = w_d_win;

    // Memory strobe is issued in the grant cycle, only for in-range accesses.
    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (w_if_win) begin
            o_mem_en   = w_if_ok;
            o_mem_addr = w_if_ok ? w_if_idx : '0;
        end else if (w_d_win) begin
            o_mem_en    = w_d_ok;
            o_mem_we    = w_d_ok && i_d_we;
            o_mem_addr  = w_d_ok ? w_d_idx : '0;
            o_mem_wdata = (w_d_ok && i_d_we) ? i_d_wdata : '0;
        end
    end

    // ------------------------------------------------------------------
    // Starvation counter and response pipeline
    // ------------------------------------------------------------------
    owner_e r_owner;    // requester receiving next cycle's response
    logic   r_err;      // that response carries an error
    logic   r_use_mem;  // that response returns memory read data

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve  <= '0;
            r_owner   <= OWN_NONE;
            r_err     <= 1'b0;
            r_use_mem <= 1'b0;
        end else begin
            // Count only cycles where fetch asked and data took the slot.
            if (!i_if_req || w_if_win) begin
                r_starve <= '0;
            end else if (!w_starved) begin
                r_starve <= r_starve + c_STARVE_ONE;
            end

            if (w_if_win) begin
                r_owner   <= OWN_IF;
                r_err     <= !w_if_ok;
                r_use_mem <= w_if_ok;
            end else if (w_d_win) begin
                r_owner   <= OWN_D;
                r_err     <= !w_d_ok;
                r_use_mem <= w_d_ok && !i_d_we;
            end else begin
                r_owner   <= OWN_NONE;
                r_err     <= 1'b0;
                r_use_mem <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response outputs
    // ------------------------------------------------------------------
    // A redirect in the response cycle kills the fetch response being
    // returned; a fetch granted in that same cycle is unaffected because its
    // response only appears in the following cycle.
    assign o_if_rvalid = (r_owner == OWN_IF) && !i_if_flush;
    assign o_if_rdata  = (o_if_rvalid && r_use_mem) ? i_mem_rdata : 32'd0;
    assign o_if_err    = o_if_rvalid && r_err;

    assign o_d_rvalid  = (r_owner == OWN_D);
    assign o_d_rdata   = (o_d_rvalid && r_use_mem) ? i_mem_rdata : 32'd0;
    assign o_d_err     = o_d_rvalid && r_err;

endmodule : imem_arb
`default_nettype wire

// File: tb/tb_imem_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_arb
//  Description : Self-checking bench for imem_arb. Stimulus tasks predict each
//                grant and response from the arbitration rules and a shadow
//                copy of memory; expected responses are queued and a monitor
//                compares them when they fall due.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_imem_arb;

    localparam int          ADDR_W     = 12;
    localparam int          STARVE_MAX = 4;
    localparam logic [31:0] BASE       = 32'h0000_3000;
    localparam int          WORDS      = 4096;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              if_req = 0, if_flush = 0;
    logic [31:0]       if_addr = 0;
    logic              if_gnt, if_rvalid, if_err;
    logic [31:0]       if_rdata;
    logic              d_req = 0, d_we = 0;
    logic [31:0]       d_addr = 0, d_wdata = 0;
    logic              d_gnt, d_rvalid, d_err;
    logic [31:0]       d_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = 0;

    always #5 clk = ~clk;

    imem_arb #(
        .ADDR_W     (ADDR_W),
        .CODE_BASE  (BASE),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_if_req    (if_req),
        .i_if_addr   (if_addr),
        .i_if_flush  (if_flush),
        .o_if_gnt    (if_gnt),
        .o_if_rvalid (if_rvalid),
        .o_if_rdata  (if_rdata),
        .o_if_err    (if_err),
        .i_d_req     (d_req),
        .i_d_we      (d_we),
        .i_d_addr    (d_addr),
        .i_d_wdata   (d_wdata),
        .o_d_gnt     (d_gnt),
        .o_d_rvalid  (d_rvalid),
        .o_d_rdata   (d_rdata),
        .o_d_err     (d_err),
        .o_mem_en    (mem_en),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata)
    );

    // Code memory attached to the DUT: word i initially holds i.
    logic [31:0] mem     [0:WORDS-1];
    logic [31:0] ref_mem [0:WORDS-1];
    initial begin
        for (int i = 0; i < WORDS; i++) begin
            mem[i]     = i;
            ref_mem[i] = i;
        end
    end
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } rsp_t;
    rsp_t ifq[$];
    rsp_t dq[$];

    int checks = 0;
    int errors = 0;
    int m_starve = 0;
    logic [5:0] pat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
        longint la;
        la = a;
        return (a[1:0] == 2'b00) && (la >= BASE) && (la < longint'(BASE) + 4 * WORDS);
    endfunction

    // Drive one cycle of requests, predict the result, check grants at negedge.
    task automatic step(input bit ir, input logic [31:0] ia, input bit fl,
                        input bit dr, input bit dwe, input logic [31:0] da,
                        input logic [31:0] dwd);
        bit   f_win, dd_win, ok, e_en, e_we;
        int   idx;
        logic [31:0] rdat;
        @(posedge clk); #1;
        if_req = ir; if_addr = ia; if_flush = fl;
        d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
        // A redirect kills the fetch response due in this cycle.
        if (fl && ifq.size() > 0 && ifq[$].due == cyc) void'(ifq.pop_back());
        f_win  = ir && (!dr || m_starve == STARVE_MAX);
        dd_win = dr && !f_win;
        e_en = 0; e_we = 0; idx = 0;
        if (f_win) begin
            ok = in_range(ia);
            idx = (ia - BASE) >> 2;
            e_en = ok;
            ifq.push_back('{cyc + 1, !ok, ok ? ref_mem[idx] : 32'd0});
        end else if (dd_win) begin
            ok = in_range(da);
            idx = (da - BASE) >> 2;
            e_en = ok;
            e_we = ok && dwe;
            rdat = (ok && !dwe) ? ref_mem[idx] : 32'd0;
            if (e_we) ref_mem[idx] = dwd;
            dq.push_back('{cyc + 1, !ok, rdat});
        end
        if (!ir || f_win) m_starve = 0;
        else if (m_starve < STARVE_MAX) m_starve++;
        @(negedge clk);
        chk("if_gnt", if_gnt, f_win);
        chk("d_gnt", d_gnt, dd_win);
        chk("mem_en", mem_en, e_en);
        if (e_en) begin
            chk("mem_addr", mem_addr, idx);
            chk("mem_we", mem_we, e_we);
            if (e_we) chk("mem_wdata", mem_wdata, dwd);
        end
        pat = {pat[4:0], if_gnt};
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Response monitor: each expected response must appear exactly when due.
    always @(negedge clk) begin
        if (!rst) begin
            if (ifq.size() > 0 && ifq[0].due <= cyc) begin
                rsp_t r;
                r = ifq.pop_front();
                chk("if_rvalid", if_rvalid, 1);
                chk("if_rdata", if_rdata, r.data);
                chk("if_err", if_err, r.err);
            end else begin
                chk("if_rvalid_idle", if_rvalid, 0);
            end
            if (dq.size() > 0 && dq[0].due <= cyc) begin
                rsp_t r;
                r = dq.pop_front();
                chk("d_rvalid", d_rvalid, 1);
                chk("d_rdata", d_rdata, r.data);
                chk("d_err", d_err, r.err);
            end else begin
                chk("d_rvalid_idle", d_rvalid, 0);
            end
        end
    end

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0: return $urandom();
            1: return BASE + 4 * $urandom_range(0, 63) + $urandom_range(1, 3);
            2: begin
                case ($urandom_range(0, 3))
                    0: return BASE - 4;
                    1: return BASE + 4 * WORDS - 4;
                    2: return BASE + 4 * WORDS;
                    default: return 32'hFFFF_FFFC;
                endcase
            end
            default: return BASE + 4 * $urandom_range(0, 63);
        endcase
    endfunction

    initial begin
        // Reset state
        #2;
        chk("rst_if_rvalid", if_rvalid, 0);
        chk("rst_d_rvalid", d_rvalid, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_if_gnt", if_gnt, 0);
        @(negedge clk); @(negedge clk);
        rst = 0;

        // Fetch-only stream
        step(1, 32'h3000, 0, 0, 0, 0, 0);
        step(1, 32'h3004, 0, 0, 0, 0, 0);
        step(1, 32'h3008, 0, 0, 0, 0, 0);
        idle(2);

        // Data write then read back
        step(0, 0, 0, 1, 1, 32'h3010, 32'hDEAD_BEEF);
        step(0, 0, 0, 1, 0, 32'h3010, 0);
        idle(2);

        // Contention: data wins four times, then fetch is forced through
        pat = '0;
        for (int i = 0; i < 6; i++) step(1, 32'h3040 + 4 * i, 0, 1, 0, 32'h3010, 0);
        chk("contention_pattern", pat, 6'b000010);
        idle(2);

        // Error responses
        step(1, 32'h2FFC, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 32'h3002, 0);
        step(1, 32'h7000, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 32'hFFFF_FFFC, 0);
        idle(2);

        // Flush in the response cycle, then request+flush together
        step(1, 32'h3000, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(1, 32'h3020, 1, 0, 0, 0, 0);
        idle(2);
        step(1, 32'h3000, 0, 0, 0, 0, 0);
        step(1, 32'h3020, 1, 0, 0, 0, 0);
        idle(2);

        // Asynchronous reset between a grant and its response
        step(1, 32'h3004, 0, 1, 0, 32'h3008, 0);
        @(posedge clk); #2;
        if_req = 0; d_req = 0; if_flush = 0;
        rst = 1;
        #1;
        chk("midrst_d_rvalid", d_rvalid, 0);
        chk("midrst_if_rvalid", if_rvalid, 0);
        chk("midrst_d_rdata", d_rdata, 0);
        ifq.delete();
        dq.delete();
        m_starve = 0;
        #1 rst = 0;
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, rand_addr(),
                 $urandom());
        end
        idle(3);
        chk("ifq_drained", ifq.size(), 0);
        chk("dq_drained", dq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_imem_arb
`default_nettype wire
